// File: rtl/lif_pkg.sv
// Shared types and default widths for the leaky integrate-and-fire soma.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lif_pkg;

    localparam int POT_W_DEF    = 8;
    localparam int MEM_W_DEF    = 10;
    localparam int REFRAC_W_DEF = 4;

    localparam logic [MEM_W_DEF-1:0] MEM_MAX = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRE   = 2'd1,
        REFRAC = 2'd2
    } lif_state_e;

endpackage

// File: rtl/lif_neuron_if.sv
// Timestep handshake, per-timestep configuration and soma outputs.
// Latency: n/a (wiring only).
// Backpressure: ready is low only during the single FIRE cycle.
interface lif_neuron_if
    import lif_pkg::*;
#(
    parameter int POT_W    = POT_W_DEF,
    parameter int MEM_W    = MEM_W_DEF,
    parameter int REFRAC_W = REFRAC_W_DEF
);
    logic                acc_valid;
    logic [POT_W-1:0]    acc_in;
    logic [MEM_W-1:0]    threshold;
    logic [2:0]          leak_shift;
    logic [REFRAC_W-1:0] refrac_len;
    logic                ready;
    logic                spk_out;
    logic [MEM_W-1:0]    mem_out;
    logic                refrac_active;

    modport master (
        output acc_valid, acc_in, threshold, leak_shift, refrac_len,
        input  ready, spk_out, mem_out, refrac_active
    );

    modport slave (
        input  acc_valid, acc_in, threshold, leak_shift, refrac_len,
        output ready, spk_out, mem_out, refrac_active
    );
endinterface

// File: rtl/lif_leak_sat.sv
// Leak, integrate and saturate one timestep of membrane potential.
// Latency: combinational.
// Backpressure: none.
module lif_leak_sat
    import lif_pkg::*;
#(
    parameter int POT_W = POT_W_DEF,
    parameter int MEM_W = MEM_W_DEF
) (
    input  logic [MEM_W-1:0] mem,
    input  logic [POT_W-1:0] acc_in,
    input  logic [2:0]       leak_shift,
    output logic [MEM_W-1:0] sum
);
    logic [MEM_W-1:0] leak;
    logic [MEM_W-1:0] leaked;
    logic [MEM_W:0]   wide;

    // leak is always <= mem, so the subtraction cannot underflow
    always_comb begin
        leak   = (leak_shift != 3'd0) ? (mem >> leak_shift) : '0;
        leaked = mem - leak;
        wide   = {1'b0, leaked} + {{(MEM_W+1-POT_W){1'b0}}, acc_in};
        sum    = wide[MEM_W] ? {MEM_W{1'b1}} : wide[MEM_W-1:0];
    end
endmodule

// File: rtl/lif_neuron.sv
// LIF soma: integrate per timestep, 1-cycle spike, refractory hold. LIF_SOFT_RESET_EN keeps residual after fire.
// Latency: spk_out/mem_out visible the cycle after the accepting edge.
// Backpressure: ready drops for the FIRE cycle only; pulses there are dropped.
module lif_neuron
    import lif_pkg::*;
#(
    parameter int POT_W    = POT_W_DEF,
    parameter int MEM_W    = MEM_W_DEF,
    parameter int REFRAC_W = REFRAC_W_DEF
) (
    input  logic         clk,
    input  logic         reset_n,
    lif_neuron_if.slave  bus
);
    localparam logic [REFRAC_W-1:0] CNT_ONE = 1;

    lif_state_e          state_q, state_d;
    logic [MEM_W-1:0]    mem_q, mem_d;
    logic [REFRAC_W-1:0] cnt_q, cnt_d;
    logic [REFRAC_W-1:0] rlen_q, rlen_d;
    logic [MEM_W-1:0]    sum;
    logic [MEM_W-1:0]    post_fire;
    logic                fire_hit;
    logic                accept;

    lif_leak_sat #(
        .POT_W (POT_W),
        .MEM_W (MEM_W)
    ) u_leak_sat (
        .mem        (mem_q),
        .acc_in     (bus.acc_in),
        .leak_shift (bus.leak_shift),
        .sum        (sum)
    );

    assign accept   = bus.acc_valid && bus.ready;
    assign fire_hit = (bus.threshold != '0) && (sum >= bus.threshold);

`ifdef LIF_SOFT_RESET_EN
    assign post_fire = sum - bus.threshold;
`else
    assign post_fire = '0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            mem_q   <= '0;
            cnt_q   <= '0;
            rlen_q  <= '0;
        end else begin
            state_q <= state_d;
            mem_q   <= mem_d;
            cnt_q   <= cnt_d;
            rlen_q  <= rlen_d;
        end
    end

    // refrac_len is captured on the accept so the FIRE cycle uses the value seen then
    always_comb begin
        state_d = state_q;
        mem_d   = mem_q;
        cnt_d   = cnt_q;
        rlen_d  = rlen_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    rlen_d = bus.refrac_len;
                    if (fire_hit) begin
                        mem_d   = post_fire;
                        state_d = FIRE;
                    end else begin
                        mem_d = sum;
                    end
                end
            end
            FIRE: begin
                if (rlen_q != '0) begin
                    cnt_d   = rlen_q;
                    state_d = REFRAC;
                end else begin
                    state_d = IDLE;
                end
            end
            REFRAC: begin
                if (accept) begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.ready         = (state_q != FIRE);
    assign bus.spk_out       = (state_q == FIRE);
    assign bus.refrac_active = (state_q == REFRAC);
    assign bus.mem_out       = mem_q;
endmodule

// File: tb/tb_lif_neuron.sv
// Directed bench for lif_neuron with a scoreboard of per-timestep expectations.
// Build with LIF_SOFT_RESET_EN defined to exercise the residual-keeping variant.
module tb_lif_neuron;
    import lif_pkg::*;

`ifdef LIF_SOFT_RESET_EN
    localparam bit SOFT = 1'b1;
`else
    localparam bit SOFT = 1'b0;
`endif

    typedef struct {
        string      tag;
        logic [9:0] mem;
        logic       spk;
        logic       ract;
    } exp_t;

    logic clk;
    logic reset_n;
    int   n_tests;
    int   n_fail;
    exp_t sb[$];

    lif_neuron_if bus ();

    lif_neuron dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_mem"},   bus.mem_out, 0);
        check({tag, "_spk"},   bus.spk_out, 0);
        check({tag, "_ract"},  bus.refrac_active, 0);
        check({tag, "_ready"}, bus.ready, 1);
    endtask

    // One timestep: wait (bounded) for ready, pulse acc_valid, then compare at the next cycle.
    task automatic step(input string tag, input logic [7:0] acc,
                        input logic [9:0] emem, input logic espk, input logic eract);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while (bus.ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_rdywait"}, bus.ready, 1);
        bus.acc_valid = 1'b1;
        bus.acc_in    = acc;
        sb.push_back('{tag: tag, mem: emem, spk: espk, ract: eract});
        @(posedge clk);
        #1;
        bus.acc_valid = 1'b0;
        e = sb.pop_front();
        check({e.tag, "_mem"},  bus.mem_out, e.mem);
        check({e.tag, "_spk"},  bus.spk_out, e.spk);
        check({e.tag, "_ract"}, bus.refrac_active, e.ract);
    endtask

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        reset_n        = 1'b0;
        bus.acc_valid  = 1'b0;
        bus.acc_in     = '0;
        bus.threshold  = 10'd300;
        bus.leak_shift = 3'd0;
        bus.refrac_len = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Integrate to threshold with no leak; hard or soft both land on 0 here
        step("t2_a", 8'd100, 10'd100, 1'b0, 1'b0);
        step("t2_b", 8'd100, 10'd200, 1'b0, 1'b0);
        step("t2_fire", 8'd100, 10'd0, 1'b1, 1'b0);
        check("t2_fire_ready", bus.ready, 0);
        @(posedge clk);
        #1;
        check_idle_outputs("t2_after");

        // Repeated >>2 leak with zero input
        step("t3_load", 8'd200, 10'd200, 1'b0, 1'b0);
        bus.leak_shift = 3'd2;
        step("t3_l1", 8'd0, 10'd150, 1'b0, 1'b0);
        step("t3_l2", 8'd0, 10'd113, 1'b0, 1'b0);
        step("t3_l3", 8'd0, 10'd85,  1'b0, 1'b0);

        // Fire with refrac_len=2; changing refrac_len during FIRE must not matter
        bus.leak_shift = 3'd0;
        bus.refrac_len = 4'd2;
        step("t4_fire", 8'd215, 10'd0, 1'b1, 1'b0);
        bus.refrac_len = 4'd0;
        @(posedge clk);
        #1;
        check("t4_ract_entry", bus.refrac_active, 1);
        check("t4_spk_clear",  bus.spk_out, 0);
        step("t4_r1", 8'd255, 10'd0,   1'b0, 1'b1);
        step("t4_r2", 8'd255, 10'd0,   1'b0, 1'b0);
        step("t4_int", 8'd255, 10'd255, 1'b0, 1'b0);

        // Firing disabled: saturate at the membrane maximum without spiking
        bus.threshold = 10'd0;
        step("t5_s1", 8'd255, 10'd510,  1'b0, 1'b0);
        step("t5_s2", 8'd255, 10'd765,  1'b0, 1'b0);
        step("t5_s3", 8'd255, 10'd1020, 1'b0, 1'b0);
        step("t5_s4", 8'd255, MEM_MAX,  1'b0, 1'b0);
        step("t5_s5", 8'd255, MEM_MAX,  1'b0, 1'b0);

        // Threshold at the maximum fires; a pulse during FIRE is dropped
        bus.threshold = 10'd1023;
        step("t5_fire", 8'd0, 10'd0, 1'b1, 1'b0);
        @(negedge clk);
        bus.acc_valid = 1'b1;
        bus.acc_in    = 8'd77;
        @(posedge clk);
        #1;
        bus.acc_valid = 1'b0;
        check_idle_outputs("t5_drop");

        // Post-fire value: residual with soft reset, zero otherwise
        bus.threshold = 10'd300;
        step("t6_load", 8'd250, 10'd250, 1'b0, 1'b0);
        step("t6_fire", 8'd100, SOFT ? 10'd50 : 10'd0, 1'b1, 1'b0);

        // Reset in the middle of a refractory period
        bus.threshold  = 10'd10;
        bus.refrac_len = 4'd3;
        step("t1_fire", 8'd20, SOFT ? 10'd60 : 10'd0, 1'b1, 1'b0);
        bus.refrac_len = 4'd0;
        step("t1_r1", 8'd9, SOFT ? 10'd60 : 10'd0, 1'b0, 1'b1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_idle_outputs("t1_async");
        @(posedge clk);
        #1;
        check_idle_outputs("t1_next");
        @(negedge clk);
        reset_n = 1'b1;

        // No refractory count survives reset; small mem is held under leak
        bus.threshold = 10'd300;
        step("hold_load", 8'd3, 10'd3, 1'b0, 1'b0);
        bus.leak_shift = 3'd2;
        step("hold_leak", 8'd0, 10'd3, 1'b0, 1'b0);

        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
